// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, opcode/funct
// constants and the ALU / operand / PC-source select encodings.
package mc_control_pkg;

    typedef logic [3:0] state_t;

    localparam state_t FETCH    = 4'd0;
    localparam state_t DECODE   = 4'd1;
    localparam state_t MEM_ADDR = 4'd2;
    localparam state_t MEM_RD   = 4'd3;
    localparam state_t MEM_WB   = 4'd4;
    localparam state_t MEM_WR   = 4'd5;
    localparam state_t R_EX     = 4'd6;
    localparam state_t R_WB     = 4'd7;
    localparam state_t I_EX     = 4'd8;
    localparam state_t I_WB     = 4'd9;
    localparam state_t BRANCH   = 4'd10;
    localparam state_t JUMP     = 4'd11;
    localparam state_t TRAP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // alu_sel encoding is shared with the ALU datapath
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

endpackage

// File: rtl/mc_control_alu_decode.sv
// Maps the latched R-type funct field to an ALU operation and flags
// unsupported funct codes.
module alu_decode
    import mc_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] alu_sel,
    output logic       illegal
);

    always_comb begin
        alu_sel = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_sel = ALU_ADD;
            FN_SUB:  alu_sel = ALU_SUB;
            FN_AND:  alu_sel = ALU_AND;
            FN_OR:   alu_sel = ALU_OR;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control FSM (Moore decode of the state register).
// Define ILLEGAL_TRAP_EN to trap illegal instructions in a sticky TRAP state.
module mc_control
    import mc_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_sel,
    output logic [1:0] pc_src,
    output logic [3:0] state_o,
    output logic       illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = TRAP;
`else
    localparam state_t ILLEGAL_NEXT = FETCH;
`endif

    state_t     state;
    state_t     state_n;
    logic [5:0] funct_q;
    logic       store_q;
    logic [1:0] fn_sel;
    logic       fn_illegal;

    alu_decode u_alu_decode (
        .funct   (funct_q),
        .alu_sel (fn_sel),
        .illegal (fn_illegal)
    );

    always_comb begin
        state_n = state;
        case (state)
            FETCH:    if (mem_ready) state_n = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_n = MEM_ADDR;
                    OP_RTYPE:     state_n = R_EX;
                    OP_ADDI:      state_n = I_EX;
                    OP_BEQ:       state_n = BRANCH;
                    OP_J:         state_n = JUMP;
                    default:      state_n = ILLEGAL_NEXT;
                endcase
            end
            // lw/sw choice comes from the opcode captured in DECODE
            MEM_ADDR: state_n = store_q ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) state_n = MEM_WB;
            MEM_WR:   if (mem_ready) state_n = FETCH;
            R_EX:     state_n = fn_illegal ? ILLEGAL_NEXT : R_WB;
            I_EX:     state_n = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_n = FETCH;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     state_n = TRAP;
`endif
            default:  state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            funct_q <= '0;
            store_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DECODE) begin
                funct_q <= funct;
                store_q <= (opcode == OP_SW);
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (state_n == TRAP)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Only ir_write/pc_en in FETCH and pc_en in BRANCH look at inputs
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_sel    = ALU_ADD;
        pc_src     = PC_ALU;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE:   alu_src_b = SRCB_IMM_SH2;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            R_EX: begin
                alu_src_a = 1'b1;
                alu_sel   = fn_sel;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            I_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            I_WB:     reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_en     = zero;
            end
            JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule
